// File: rtl/mouse_packet_sequencer.sv
// PS/2 mouse front-end: runs the reset/self-test/enable handshake, then assembles
// 3-byte stream packets into STATUS/DX/DY with a one-cycle INTERRUPT per packet.
module mouse_packet_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERR,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] STATE_DBG
);

  typedef enum logic [3:0] {
    StSendRst  = 4'd0,
    StWaitTx1  = 4'd1,
    StWaitAck1 = 4'd2,
    StWaitBat  = 4'd3,
    StWaitId   = 4'd4,
    StSendEn   = 4'd5,
    StWaitTx2  = 4'd6,
    StWaitAck2 = 4'd7,
    StRxB0     = 4'd8,
    StRxB1     = 4'd9,
    StRxB2     = 4'd10
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             send_q, send_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       status_hold_q, status_hold_d;
  logic [7:0]       dx_hold_q, dx_hold_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       dx_q, dx_d;
  logic [7:0]       dy_q, dy_d;
  logic             irq_q, irq_d;

  logic byte_ok;
  logic byte_bad;
  logic timeout;
  logic in_tx_wait;

  // An error strobe wins over a simultaneous valid strobe.
  assign byte_ok    = BYTE_VALID & ~BYTE_ERR;
  assign timeout    = (cnt_q == TimeoutVal);
  assign byte_bad   = BYTE_ERR | timeout;
  assign in_tx_wait = (state_q == StWaitTx1) || (state_q == StWaitTx2);

  function automatic logic [7:0] clamp(input logic ovf, input logic sign, input logic [7:0] d);
    if (!ovf) return d;
    return sign ? 8'h80 : 8'h7F;
  endfunction

  always_comb begin
    state_d       = state_q;
    send_d        = 1'b0;
    tx_byte_d     = tx_byte_q;
    status_hold_d = status_hold_q;
    dx_hold_d     = dx_hold_q;
    status_d      = status_q;
    dx_d          = dx_q;
    dy_d          = dy_q;
    irq_d         = 1'b0;

    unique case (state_q)
      StSendRst: begin
        tx_byte_d = 8'hFF;
        send_d    = 1'b1;
        state_d   = StWaitTx1;
      end
      StWaitTx1: begin
        if (byte_bad)       state_d = StSendRst;
        else if (BYTE_SENT) state_d = StWaitAck1;
      end
      StWaitAck1: begin
        if (byte_bad)     state_d = StSendRst;
        else if (byte_ok) state_d = (BYTE_IN == 8'hFA) ? StWaitBat : StSendRst;
      end
      StWaitBat: begin
        if (byte_bad)     state_d = StSendRst;
        else if (byte_ok) state_d = (BYTE_IN == 8'hAA) ? StWaitId : StSendRst;
      end
      StWaitId: begin
        if (byte_bad)     state_d = StSendRst;
        else if (byte_ok) state_d = (BYTE_IN == 8'h00) ? StSendEn : StSendRst;
      end
      StSendEn: begin
        tx_byte_d = 8'hF4;
        send_d    = 1'b1;
        state_d   = StWaitTx2;
      end
      StWaitTx2: begin
        if (byte_bad)       state_d = StSendRst;
        else if (BYTE_SENT) state_d = StWaitAck2;
      end
      StWaitAck2: begin
        if (byte_bad)     state_d = StSendRst;
        else if (byte_ok) state_d = (BYTE_IN == 8'hFA) ? StRxB0 : StSendRst;
      end
      StRxB0: begin
        // Bit 3 is always set in a status byte; anything else is a resync discard.
        if (byte_ok && BYTE_IN[3]) begin
          status_hold_d = BYTE_IN;
          state_d       = StRxB1;
        end
      end
      StRxB1: begin
        if (byte_bad) begin
          state_d = StRxB0;
        end else if (byte_ok) begin
          dx_hold_d = BYTE_IN;
          state_d   = StRxB2;
        end
      end
      StRxB2: begin
        if (byte_bad) begin
          state_d = StRxB0;
        end else if (byte_ok) begin
          status_d = status_hold_q;
          dx_d     = clamp(status_hold_q[6], status_hold_q[4], dx_hold_q);
          dy_d     = clamp(status_hold_q[7], status_hold_q[5], BYTE_IN);
          irq_d    = 1'b1;
          state_d  = StRxB0;
        end
      end
      default: state_d = StSendRst;
    endcase
  end

  // Saturating counter; echoes seen while waiting on the transmitter do not restart it.
  always_comb begin
    cnt_d = timeout ? cnt_q : cnt_q + CNT_W'(1);
    if ((state_d != state_q) || (BYTE_VALID && !in_tx_wait)) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StSendRst;
      cnt_q         <= '0;
      send_q        <= 1'b0;
      tx_byte_q     <= 8'h00;
      status_hold_q <= 8'h00;
      dx_hold_q     <= 8'h00;
      status_q      <= 8'h00;
      dx_q          <= 8'h00;
      dy_q          <= 8'h00;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      send_q        <= send_d;
      tx_byte_q     <= tx_byte_d;
      status_hold_q <= status_hold_d;
      dx_hold_q     <= dx_hold_d;
      status_q      <= status_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      irq_q         <= irq_d;
    end
  end

  assign SEND_BYTE    = send_q;
  assign BYTE_TO_SEND = tx_byte_q;
  assign MOUSE_STATUS = status_q;
  assign MOUSE_DX     = dx_q;
  assign MOUSE_DY     = dy_q;
  assign INTERRUPT    = irq_q;
  assign INIT_DONE    = (state_q == StRxB0) || (state_q == StRxB1) || (state_q == StRxB2);
  assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_mouse_packet_sequencer.sv
// Scoreboard bench for mouse_packet_sequencer: expected packets queued as bytes are
// driven, observed packets captured on INTERRUPT, and both compared per scenario.
module tb_mouse_packet_sequencer;

  localparam int unsigned TimeoutCycles = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_err = 1'b0;
  logic       byte_sent = 1'b0;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic [7:0] m_status, m_dx, m_dy;
  logic       interrupt, init_done;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  tx_q[$];

  mouse_packet_sequencer #(
    .TIMEOUT_CYCLES(TimeoutCycles),
    .CNT_W(26)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .BYTE_IN(byte_in),
    .BYTE_VALID(byte_valid),
    .BYTE_ERR(byte_err),
    .SEND_BYTE(send_byte),
    .BYTE_TO_SEND(byte_to_send),
    .BYTE_SENT(byte_sent),
    .MOUSE_STATUS(m_status),
    .MOUSE_DX(m_dx),
    .MOUSE_DY(m_dy),
    .INTERRUPT(interrupt),
    .INIT_DONE(init_done),
    .STATE_DBG(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (interrupt) obs_q.push_back({m_status, m_dx, m_dy});
    if (send_byte) tx_q.push_back(byte_to_send);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [23:0] model(input logic [7:0] s, input logic [7:0] x,
                                        input logic [7:0] y);
    logic [7:0] xo, yo;
    xo = s[6] ? (s[4] ? 8'h80 : 8'h7F) : x;
    yo = s[7] ? (s[5] ? 8'h80 : 8'h7F) : y;
    return {s, xo, yo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic put_err();
    byte_err = 1'b1;
    tick();
    byte_err = 1'b0;
  endtask

  task automatic ack();
    byte_sent = 1'b1;
    tick();
    byte_sent = 1'b0;
  endtask

  task automatic wait_send(input int limit, output int cycles);
    cycles = 0;
    while (!send_byte && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic push_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back(model(s, x, y));
    put(s);
    put(x);
    put(y);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({send_byte, byte_to_send, interrupt, init_done} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected 000",
               {send_byte, byte_to_send, interrupt, init_done});
    end
    n_checks++;
    if ({m_status, m_dx, m_dy} !== 24'h000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000000", {m_status, m_dx, m_dy});
    end
    n_checks++;
    if (state_dbg !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    int c;
    logic [7:0] t;
    tx_q.delete();
    wait_send(20, c);
    n_checks++;
    if (send_byte !== 1'b1) begin
      n_fail++;
      $display("FAIL init_req_rst: got %b expected 1 within 20 cycles", send_byte);
    end
    put(8'hFA);  // echo while waiting on the transmitter
    n_checks++;
    if (state_dbg !== 4'd1) begin
      n_fail++;
      $display("FAIL init_tx_echo: got state %0d expected 1", state_dbg);
    end
    ack();
    put(8'hFA);
    put(8'hAA);
    put(8'h00);
    wait_send(20, c);
    n_checks++;
    if (send_byte !== 1'b1) begin
      n_fail++;
      $display("FAIL init_req_en: got %b expected 1 within 20 cycles", send_byte);
    end
    ack();
    put(8'hFA);
    n_checks++;
    if (tx_q.size() != 2) begin
      n_fail++;
      $display("FAIL init_tx_count: got %0d expected 2", tx_q.size());
    end else begin
      t = tx_q.pop_front();
      n_checks++;
      if (t !== 8'hFF) begin
        n_fail++;
        $display("FAIL init_tx_rst: got %h expected ff", t);
      end
      t = tx_q.pop_front();
      n_checks++;
      if (t !== 8'hF4) begin
        n_fail++;
        $display("FAIL init_tx_en: got %h expected f4", t);
      end
    end
    n_checks++;
    if ({init_done, state_dbg} !== 5'h18) begin
      n_fail++;
      $display("FAIL init_done: got done=%b state=%0d expected done=1 state=8",
               init_done, state_dbg);
    end
  endtask

  task automatic test_packet();
    logic [23:0] e, o;
    push_pkt(8'h08, 8'h05, 8'hFD);
    n_checks++;
    if ({interrupt, m_status, m_dx, m_dy} !== {1'b1, 24'h0805FD}) begin
      n_fail++;
      $display("FAIL pkt_latency: got %h expected 10805fd", {interrupt, m_status, m_dx, m_dy});
    end
    tick();
    n_checks++;
    if (interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_irq_width: got %b expected 0", interrupt);
    end
    repeat (20) tick();
    n_checks++;
    if ({m_status, m_dx, m_dy} !== 24'h0805FD) begin
      n_fail++;
      $display("FAIL pkt_hold: got %h expected 0805fd", {m_status, m_dx, m_dy});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL pkt_sb_missing: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL pkt_sb: got %h expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL pkt_sb_extra: got %0d extra expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_resync();
    logic [23:0] e, o;
    put(8'h00);
    push_pkt(8'h09, 8'h10, 8'h20);
    repeat (3) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL resync_sb_missing: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL resync_sb: got %h expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL resync_sb_extra: got %0d extra expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_err_drop();
    logic [23:0] e, o;
    put(8'h08);
    put(8'h05);
    put_err();
    repeat (5) tick();
    n_checks++;
    if (obs_q.size() != 0 || {m_status, m_dx, m_dy} !== 24'h091020) begin
      n_fail++;
      $display("FAIL err_drop: got irqs=%0d out=%h expected irqs=0 out=091020",
               obs_q.size(), {m_status, m_dx, m_dy});
      obs_q.delete();
    end
    push_pkt(8'h18, 8'hFF, 8'h01);
    n_checks++;
    if ({m_status, m_dx, m_dy} !== 24'h18FF01) begin
      n_fail++;
      $display("FAIL err_recover: got %h expected 18ff01", {m_status, m_dx, m_dy});
    end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL err_sb_missing: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL err_sb: got %h expected %h", o, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e, o;
    push_pkt(8'h58, 8'h12, 8'h34);
    n_checks++;
    if ({m_status, m_dx, m_dy} !== 24'h588034) begin
      n_fail++;
      $display("FAIL ovf_x: got %h expected 588034", {m_status, m_dx, m_dy});
    end
    push_pkt(8'hE8, 8'h00, 8'h00);
    push_pkt(8'h29, 8'h81, 8'h7E);
    push_pkt(8'h3C, 8'h01, 8'h02);  // overflow signs set but no overflow
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_sb_missing: got none expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL b2b_sb: got %h expected %h", o, e);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_sb_extra: got %0d extra expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    put(8'h08);
    put(8'h05);
    byte_in = 8'h33;
    byte_valid = 1'b1;
    rst = 1'b1;
    tick();
    byte_valid = 1'b0;
    n_checks++;
    if ({interrupt, m_status, m_dx, m_dy, state_dbg} !== 29'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got irq=%b out=%h state=%0d expected 0/000000/0",
               interrupt, {m_status, m_dx, m_dy}, state_dbg);
    end
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_irq: got %0d expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_init_errors();
    int c;
    logic [7:0] t;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_q.delete();
    wait_send(20, c);
    ack();
    put(8'hFA);
    put(8'h00);  // wrong BAT byte
    wait_send(10, c);
    n_checks++;
    if (send_byte !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_bat: got %b expected resend within 10 cycles", send_byte);
    end
    ack();
    put(8'hFA);
    put(8'hAA);
    put_err();
    wait_send(10, c);
    n_checks++;
    if (send_byte !== 1'b1) begin
      n_fail++;
      $display("FAIL err_id: got %b expected resend within 10 cycles", send_byte);
    end
    ack();
    wait_send(300, c);
    n_checks++;
    if (send_byte !== 1'b1 || c < 90 || c > 120) begin
      n_fail++;
      $display("FAIL ack_timeout: got send=%b after %0d cycles expected 1 after 90..120",
               send_byte, c);
    end
    ack();
    n_checks++;
    if (tx_q.size() != 4) begin
      n_fail++;
      $display("FAIL retry_tx_count: got %0d expected 4", tx_q.size());
    end
    while (tx_q.size() != 0) begin
      t = tx_q.pop_front();
      n_checks++;
      if (t !== 8'hFF) begin
        n_fail++;
        $display("FAIL retry_tx_byte: got %h expected ff", t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_packet();
    test_resync();
    test_err_drop();
    test_back_to_back();
    test_mid_reset();
    test_init();
    test_packet();
    test_init_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
